tristate_bus_arbiter: RTL and testbench

//  Shares one tristate bus line among N requesters by sequencing one-hot drive enables to their tristate buffers.

---
 rtl/tristate_bus_arbiter_pkg.sv | 33 +++
 rtl/tristate_bus_arbiter_rr_pick.sv | 44 ++++
 rtl/tristate_bus_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_tristate_bus_arbiter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tristate_bus_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// tsb_arb_pkg
//   Shared types and constants for the tristate bus arbiter.
//   - arb_state_e : arbiter FSM states (IDLE, TURN, OWN)
//   - SEL_W       : select width for the default build of four requesters;
//                   the top derives its own width from its N parameter
//   - TURN_W      : width of the turnaround down-counter (TURN_CYC <= 15)
//   - arb_next_ptr: round-robin successor of an index, wrapping at n
// ---------------------------------------------------------------------------
package tsb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TURN = 2'd1,
        OWN  = 2'd2
    } arb_state_e;

    localparam int N_DEFAULT = 4;
    localparam int SEL_W     = $clog2(N_DEFAULT);
    localparam int TURN_W    = 4;

    // Round-robin successor: idx + 1, wrapping to 0 after n - 1.
    function automatic int arb_next_ptr(input int idx, input int n);
        int nxt;
        if (idx >= n - 1) begin
            nxt = 0;
        end else begin
            nxt = idx + 1;
        end
        return nxt;
    endfunction

endpackage : tsb_arb_pkg

// File: rtl/tristate_bus_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
//   Combinational rotating priority encoder. Returns the first set request
//   bit when searching ptr_i, ptr_i+1, ... wrapping modulo N.
// Ports
//   req_i   [N]          request vector
//   ptr_i   [$clog2(N)]  starting search position (must be < N)
//   valid_o              at least one request set
//   idx_o   [$clog2(N)]  index of the winning request (0 when none)
// ---------------------------------------------------------------------------
module rr_pick
    import tsb_arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]         req_i,
    input  logic [$clog2(N)-1:0] ptr_i,
    output logic                 valid_o,
    output logic [$clog2(N)-1:0] idx_o
);

    localparam int IDX_W = $clog2(N);
    localparam int POS_W = IDX_W + 1;
    localparam logic [POS_W-1:0] N_L = POS_W'(N);

    logic [POS_W-1:0] pos_s;
    logic [IDX_W-1:0] cand_s;

    // Walk candidates from farthest to nearest so the nearest set bit is the
    // last one written and therefore wins.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        pos_s   = '0;
        cand_s  = '0;
        for (int i = N - 1; i >= 0; i--) begin
            pos_s   = {1'b0, ptr_i} + POS_W'(i);
            cand_s  = (pos_s >= N_L) ? IDX_W'(pos_s - N_L) : IDX_W'(pos_s);
            valid_o = valid_o | req_i[cand_s];
            idx_o   = req_i[cand_s] ? cand_s : idx_o;
        end
    end

endmodule : rr_pick

// File: rtl/tristate_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tristate_bus_arbiter
//   Shares one tristate bus line among N requesters. Grants round-robin,
//   inserts an all-off turnaround (one IDLE cycle plus TURN_CYC cycles)
//   before any driver turns on, and never raises more than one enable.
//
// Optional feature (macro ARB_HOLD_TIMEOUT_EN):
//   when defined, an owner is forcibly released after MAX_HOLD OWN cycles
//   and timeout_err pulses for one cycle as its enable drops. When
//   undefined, ownership is unbounded and timeout_err is tied low.
//
// Parameters
//   N         number of requesters (2..16)
//   TURN_CYC  undriven cycles between grant and enable (0..15)
//   MAX_HOLD  OWN cycles before forced release (macro builds only)
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   req  [N]     level request, held until released
//   rel  [N]     release pulse, only rel[sel] is honoured
//   gnt  [N]     one-hot grant (registered)
//   oe   [N]     one-hot tristate drive enables (registered)
//   sel          index of current / last grantee
//   busy         high in TURN and OWN
//   timeout_err  one-cycle pulse on forced release
// ---------------------------------------------------------------------------
module tristate_bus_arbiter
    import tsb_arb_pkg::*;
#(
    parameter int N        = 4,
    parameter int TURN_CYC = 1,
    parameter int MAX_HOLD = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic [N-1:0]         rel,
    output logic [N-1:0]         gnt,
    output logic [N-1:0]         oe,
    output logic [$clog2(N)-1:0] sel,
    output logic                 busy,
    output logic                 timeout_err
);

    localparam int IDX_W = $clog2(N);

    if ((N < 2) || (N > 16)) begin : g_bad_n
        $error("tristate_bus_arbiter: N must lie in 2..16");
    end
    if ((TURN_CYC < 0) || (TURN_CYC > 15)) begin : g_bad_turn
        $error("tristate_bus_arbiter: TURN_CYC must lie in 0..15");
    end
    if (MAX_HOLD < 1) begin : g_bad_hold
        $error("tristate_bus_arbiter: MAX_HOLD must be at least 1");
    end

    arb_state_e        state_q;
    logic [N-1:0]      gnt_q;
    logic [N-1:0]      oe_q;
    logic [IDX_W-1:0]  sel_q;
    logic [IDX_W-1:0]  ptr_q;
    logic              busy_q;
    logic [TURN_W-1:0] cnt_q;

    logic              pick_valid_s;
    logic [IDX_W-1:0]  pick_idx_s;
    logic [N-1:0]      pick_oh_s;
    logic [IDX_W-1:0]  ptr_d;
    logic              req_sel_s;
    logic              rel_sel_s;
    logic              hold_hit_s;
    logic              own_exit_s;

    rr_pick #(
        .N (N)
    ) u_rr_pick (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .valid_o (pick_valid_s),
        .idx_o   (pick_idx_s)
    );

    assign pick_oh_s = {{(N-1){1'b0}}, 1'b1} << pick_idx_s;
    assign req_sel_s = req[sel_q];
    assign rel_sel_s = rel[sel_q];
    assign own_exit_s = rel_sel_s | ~req_sel_s | hold_hit_s;

    // Pointer to resume arbitration from once the current grantee leaves.
    always_comb begin
        ptr_d = IDX_W'(arb_next_ptr(int'(sel_q), N));
    end

`ifdef ARB_HOLD_TIMEOUT_EN
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);

    logic [HOLD_W-1:0] hold_q;
    logic              terr_q;

    // The MAX_HOLD-th OWN cycle is the last one the owner keeps its enable.
    assign hold_hit_s = (state_q == OWN) && (hold_q == HOLD_W'(MAX_HOLD - 1));

    // Hold counter: counts OWN cycles, zero everywhere else so it starts
    // clean on every entry to OWN; timeout pulse lands with oe clearing.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q <= '0;
            terr_q <= 1'b0;
        end else begin
            terr_q <= hold_hit_s;
            if ((state_q == OWN) && !own_exit_s) begin
                hold_q <= hold_q + HOLD_W'(1);
            end else begin
                hold_q <= '0;
            end
        end
    end

    assign timeout_err = terr_q;
`else
    assign hold_hit_s  = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // Arbiter FSM with registered grant, enable, select and busy outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            oe_q    <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    oe_q <= '0;
                    if (pick_valid_s) begin
                        gnt_q  <= pick_oh_s;
                        sel_q  <= pick_idx_s;
                        busy_q <= 1'b1;
                        if (TURN_CYC > 0) begin
                            state_q <= TURN;
                            cnt_q   <= TURN_W'(TURN_CYC);
                        end else begin
                            // No turnaround: enable follows the grant directly;
                            // the IDLE cycle already kept the bus undriven.
                            state_q <= OWN;
                            oe_q    <= pick_oh_s;
                        end
                    end else begin
                        gnt_q  <= '0;
                        busy_q <= 1'b0;
                    end
                end
                TURN: begin
                    if (!req_sel_s) begin
                        // Grantee withdrew before driving: abort, move on.
                        state_q <= IDLE;
                        gnt_q   <= '0;
                        oe_q    <= '0;
                        busy_q  <= 1'b0;
                        ptr_q   <= ptr_d;
                    end else if (cnt_q == TURN_W'(1)) begin
                        state_q <= OWN;
                        oe_q    <= gnt_q;
                    end else begin
                        cnt_q <= cnt_q - TURN_W'(1);
                    end
                end
                OWN: begin
                    if (own_exit_s) begin
                        state_q <= IDLE;
                        gnt_q   <= '0;
                        oe_q    <= '0;
                        busy_q  <= 1'b0;
                        ptr_q   <= ptr_d;
                    end else begin
                        oe_q <= gnt_q;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    gnt_q   <= '0;
                    oe_q    <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt  = gnt_q;
    assign oe   = oe_q;
    assign sel  = sel_q;
    assign busy = busy_q;

endmodule : tristate_bus_arbiter

// File: tb/tb_tristate_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_tristate_bus_arbiter
//   Directed bench for tristate_bus_arbiter. Two instances share clk/rst:
//   u0 (N=4, TURN_CYC=1, MAX_HOLD=8) and u1 (N=4, TURN_CYC=3, MAX_HOLD=8).
//   Outputs are sampled on the falling edge; inputs change right after.
//   Expected timeout behaviour follows macro ARB_HOLD_TIMEOUT_EN.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_tristate_bus_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req0, rel0, gnt0, oe0;
    logic [3:0] req1, rel1, gnt1, oe1;
    logic [1:0] sel0, sel1;
    logic       busy0, busy1, terr0, terr1;

    int n_vec = 0;
    int n_err = 0;

    logic       mon_en = 1'b0;
    logic       rst_edge_q = 1'b0;
    logic [3:0] last0 = 4'd0;
    logic [3:0] last1 = 4'd0;
    int         zr0 = 0;
    int         zr1 = 0;

    int         w;
    int         cnt;
    logic [3:0] exp_oh;

    always #5 clk = ~clk;

    tristate_bus_arbiter #(.N(4), .TURN_CYC(1), .MAX_HOLD(8)) u0 (
        .clk(clk), .rst(rst), .req(req0), .rel(rel0), .gnt(gnt0), .oe(oe0),
        .sel(sel0), .busy(busy0), .timeout_err(terr0)
    );

    tristate_bus_arbiter #(.N(4), .TURN_CYC(3), .MAX_HOLD(8)) u1 (
        .clk(clk), .rst(rst), .req(req1), .rel(rel1), .gnt(gnt1), .oe(oe1),
        .sel(sel1), .busy(busy1), .timeout_err(terr1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Invariants for one instance; returns updated last-owner / idle-run state.
    task automatic inv(input string tag, input logic [3:0] oe, input logic [3:0] gnt,
                       input int tc, input logic rs, input logic [3:0] last, input int zr,
                       output logic [3:0] ln, output int zn);
        chk({tag, "_oe_onehot0"}, 32'($onehot0(oe)), 32'd1);
        chk({tag, "_gnt_onehot0"}, 32'($onehot0(gnt)), 32'd1);
        chk({tag, "_oe_implies_gnt"}, 32'((oe == 4'd0) || (oe == gnt)), 32'd1);
        if (rs) begin
            ln = 4'd0;
            zn = 0;
        end else if (oe == 4'd0) begin
            ln = last;
            zn = zr + 1;
        end else begin
            if ((last != 4'd0) && (last != oe)) begin
                chk({tag, "_turnaround"}, 32'(zr >= 1 + tc), 32'd1);
            end
            ln = oe;
            zn = 0;
        end
    endtask

    always @(posedge clk) rst_edge_q <= rst;

    // Per-cycle invariant monitor for both instances.
    always @(negedge clk) begin : mon
        logic [3:0] l0n, l1n;
        int         z0n, z1n;
        if (mon_en) begin
            inv("u0", oe0, gnt0, 1, rst_edge_q, last0, zr0, l0n, z0n);
            inv("u1", oe1, gnt1, 3, rst_edge_q, last1, zr1, l1n, z1n);
            last0 <= l0n;
            zr0   <= z0n;
            last1 <= l1n;
            zr1   <= z1n;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not reach summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        req0 = 4'd0; rel0 = 4'd0; req1 = 4'd0; rel1 = 4'd0;

        // ---- 1: reset state and quiet idle ----
        repeat (3) @(posedge clk);
        @(negedge clk);
        mon_en = 1'b1;
        chk("t1_rst_gnt", gnt0, 4'd0);
        chk("t1_rst_oe", oe0, 4'd0);
        chk("t1_rst_sel", sel0, 2'd0);
        chk("t1_rst_busy", busy0, 1'b0);
        chk("t1_rst_terr", terr0, 1'b0);
        chk("t1_rst_u1_oe", oe1, 4'd0);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("t1_idle_gnt", gnt0, 4'd0);
            chk("t1_idle_oe", oe0, 4'd0);
            chk("t1_idle_busy", busy0, 1'b0);
            chk("t1_idle_sel", sel0, 2'd0);
        end

        // ---- 2: single request, latency and release ----
        req0 = 4'b0100;
        step();
        chk("t2_gnt", gnt0, 4'b0100);
        chk("t2_sel", sel0, 2'd2);
        chk("t2_busy", busy0, 1'b1);
        chk("t2_oe_turn", oe0, 4'd0);
        step();
        chk("t2_oe", oe0, 4'b0100);
        rel0 = 4'b0100;
        step();
        rel0 = 4'd0;
        req0 = 4'd0;
        chk("t2_rel_oe", oe0, 4'd0);
        chk("t2_rel_gnt", gnt0, 4'd0);
        chk("t2_rel_busy", busy0, 1'b0);
        chk("t2_rel_sel_held", sel0, 2'd2);
        step();
        chk("t2_idle_sel_held", sel0, 2'd2);

        // ---- 3: all requesting, round-robin 0,1,2,3,0 ----
        rst = 1'b1;
        step();
        rst = 1'b0;
        req0 = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            exp_oh = 4'b0001 << (k % 4);
            w = 0;
            while ((oe0 == 4'd0) && (w < 12)) begin
                step();
                w++;
            end
            chk("t3_wait", w, 2);
            chk("t3_owner_oe", oe0, exp_oh);
            chk("t3_owner_gnt", gnt0, exp_oh);
            step();
            step();
            chk("t3_hold3", oe0, exp_oh);
            rel0 = exp_oh;
            step();
            rel0 = 4'd0;
            chk("t3_released", oe0, 4'd0);
        end

        // ---- 5: non-grantee rel/req ignored, reset mid-OWN ----
        // Pointer now sits at 1 after owner 0 released.
        req0 = 4'b0010;
        step();
        chk("t5_gnt", gnt0, 4'b0010);
        step();
        chk("t5_oe", oe0, 4'b0010);
        rel0 = 4'b1000;
        req0 = 4'b1010;
        step();
        rel0 = 4'd0;
        chk("t5_ignored_oe", oe0, 4'b0010);
        chk("t5_ignored_gnt", gnt0, 4'b0010);
        chk("t5_ignored_sel", sel0, 2'd1);
        step();
        chk("t5_still_oe", oe0, 4'b0010);
        rst = 1'b1;
        step();
        chk("t5_rst_oe", oe0, 4'd0);
        chk("t5_rst_gnt", gnt0, 4'd0);
        chk("t5_rst_busy", busy0, 1'b0);
        chk("t5_rst_sel", sel0, 2'd0);
        rst = 1'b0;
        req0 = 4'b0011;
        step();
        chk("t5_ptr0_gnt", gnt0, 4'b0001);
        step();
        chk("t5_ptr0_oe", oe0, 4'b0001);
        req0 = 4'd0;
        step();
        chk("t5_drop_oe", oe0, 4'd0);

        // ---- 4: TURN_CYC=3, abort in second TURN cycle ----
        req1 = 4'b0010;
        step();
        chk("t4_gnt", gnt1, 4'b0010);
        chk("t4_busy", busy1, 1'b1);
        chk("t4_oe_turn1", oe1, 4'd0);
        step();
        chk("t4_oe_turn2", oe1, 4'd0);
        req1 = 4'd0;
        step();
        chk("t4_abort_gnt", gnt1, 4'd0);
        chk("t4_abort_oe", oe1, 4'd0);
        chk("t4_abort_busy", busy1, 1'b0);
        req1 = 4'b1011;
        step();
        chk("t4_next_gnt", gnt1, 4'b1000);
        chk("t4_next_sel", sel1, 2'd3);
        step();
        chk("t4_turn_a", oe1, 4'd0);
        step();
        chk("t4_turn_b", oe1, 4'd0);
        step();
        chk("t4_oe_lat", oe1, 4'b1000);
        req1 = 4'd0;
        step();
        chk("t4_drop_oe", oe1, 4'd0);

        // ---- 6: hold with no release ----
        rst = 1'b1;
        step();
        rst = 1'b0;
        req0 = 4'b0001;
        step();
        step();
        cnt = 0;
`ifdef ARB_HOLD_TIMEOUT_EN
        while ((oe0 == 4'b0001) && (cnt < 20)) begin
            chk("t6_terr_low", terr0, 1'b0);
            cnt++;
            step();
        end
        chk("t6_hold_len", cnt, 8);
        chk("t6_forced_oe", oe0, 4'd0);
        chk("t6_terr_pulse", terr0, 1'b1);
        step();
        chk("t6_terr_clear", terr0, 1'b0);
`else
        while ((oe0 == 4'b0001) && (cnt < 100)) begin
            chk("t6_terr_low", terr0, 1'b0);
            cnt++;
            step();
        end
        chk("t6_hold_len", cnt, 100);
        chk("t6_still_oe", oe0, 4'b0001);
`endif
        req0 = 4'd0;
        repeat (3) step();
        chk("t6_end_oe", oe0, 4'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_tristate_bus_arbiter
